sim_step_scheduler: RTL and testbench
=====================================

# sim_step_scheduler

Sequences one simulation step of the rope/cloth node array and time-shares a single constraint solver among all adjacent node links. On each `step_start` it fires one Verlet-integration cycle to every node. It then walks every link (i, i+1) for `ITERS` relaxation passes. For each link it hands the pair's positions to the shared solver and writes the corrected positions back through the nodes' fix-constraint port. It sits between the frame timer and the node array / constraint solver.

## Interface
- `NUM_NODES`, 4: nodes in the chain, ≥2; links = NUM_NODES−1
- `ITERS`, 2: constraint relaxation passes per step, ≥1
- `W`, 32: coordinate width, signed fixed point Q20.12
- `clk` in 1: clock
- `reset` in 1: reset, synchronous, active-high
- `step_start` in 1: request one simulation step (single-cycle pulse)
- `pos_x_flat`, `pos_y_flat` in NUM_NODES·W: node positions, node k at bits [k·W +: W]
- `verlet_state` out 1: broadcast integrate strobe to all nodes
- `fix_en` out NUM_NODES: one-hot fix-constraint strobe per node
- `fix_x`, `fix_y` out W: broadcast write-back coordinate
- `req_valid` out 1 / `req_ready` in 1: solver request handshake
- `req_ax`, `req_ay`, `req_bx`, `req_by` out W: link endpoints a = node i, b = node i+1
- `resp_valid` in 1: solver result strobe
- `resp_ax`, `resp_ay`, `resp_bx`, `resp_by` in W: corrected endpoints
- `busy` out 1: step in progress
- `step_done` out 1: one-cycle pulse at step completion
- `step_overrun` out 1: one-cycle pulse when `step_start` arrives while busy

## Operation
- States: IDLE, VERLET, ISSUE, WAIT, WRITE_A, WRITE_B, DONE.
- IDLE: when `step_start` is high, clear `link` and `iter`, then go to VERLET.
- VERLET: `verlet_state`=1 for exactly one cycle, then go to ISSUE.
- ISSUE: `req_valid`=1. Operands are taken combinationally from the pos buses at indices `link` and `link`+1. The node positions are stable in this state. Stay in ISSUE until `req_valid`&&`req_ready`, then go to WAIT.
- WAIT: on `resp_valid`, capture the four results into registers and go to WRITE_A. `resp_valid` in any other state is ignored.
- WRITE_A: `fix_en`[link]=1, `fix_x`/`fix_y` = captured a result.
- WRITE_B: `fix_en`[link+1]=1, `fix_x`/`fix_y` = captured b result. Then:
  - if `link`=NUM_NODES−2: set `link`=0. If `iter`=ITERS−1 go to DONE; otherwise increment `iter` and go to ISSUE.
  - otherwise increment `link` and go to ISSUE.
- DONE: `step_done`=1 for one cycle, then go to IDLE.
- `busy`=1 in every state except IDLE.
- `step_start` while not in IDLE is dropped and pulses `step_overrun` in the same cycle as the drop.
- Results pass through unmodified. There is no arithmetic on coordinates, and counters use clog2-sized widths.

## Timing
- Reset (sync) takes effect mid-step too: state=IDLE; `link`, `iter`, and capture registers = 0; every output = 0.
- A pending solver transaction is abandoned on reset; the solver shares `reset`.
- `step_start` sampled on edge 0 gives `verlet_state` high in cycle 0→1.
- With a zero-wait solver (`req_ready`=1, `resp_valid` one cycle after accept), each link takes exactly 4 cycles.
- `step_done` rises on edge 1 + 4·ITERS·(NUM_NODES−1). Solver stalls add cycles one-for-one.
- `fix_en` is at most one-hot; it is never asserted in the same cycle as `verlet_state`.
- The earliest accepted new `step_start` is in the cycle after `step_done`.

## Configuration
- `PIN_NODE0_EN` defined: node 0 is an anchor.
  - WRITE_A with `link`=0 still takes one cycle, but `fix_en`=0 during it.
  - `verlet_state` is unchanged; the node itself handles pinning in integration.
- Undefined: all nodes are written back.

## Structure
- Shared `sim_pkg` holds:
  - `FRAC_BITS`=12 and `COORD_W`=32
  - the state enum
  - fixed-point constants `FIX_ONE`=0x1000 and `FIX_TWO`=0x2000
- Sub-module `link_operand_mux`: selects the node pair (link, link+1) from the flat buses and drives the four `req_*` operands.

## Test plan
- NUM_NODES=4, ITERS=2, zero-wait solver, `step_start` at edge 0 → `verlet_state` high for 1 cycle, 6 link transactions with `fix_en` sequence 0001,0010,0010,0100,0100,1000 repeated twice, `step_done` on edge 25.
- Solver holds `req_ready` low for 3 cycles on link 1 → `req_ax`/`req_ay`/`req_bx`/`req_by` held stable (nodes 1, 2), `step_done` delayed exactly 3 cycles.
- Solver returns a=(0x0C8000,0x00A000), b=(0x0D2000,0x014000) → WRITE_A drives those a values with `fix_en`=0010, then WRITE_B drives b with `fix_en`=0100.
- `step_start` pulsed on edge 5 while busy → `step_overrun` pulse on edge 5, no second step, single `step_done`.
- `reset` asserted in WAIT → next cycle state IDLE, all outputs 0, a following `resp_valid` is ignored, a new `step_start` runs a full step.
- `PIN_NODE0_EN` defined → the link-0 WRITE_A cycle shows `fix_en`=0000, while total latency is unchanged (edge 25).

Source files
------------

// File: rtl/sim_pkg.sv
// Shared definitions for the simulation-step scheduler slice.
// Holds the coordinate format (Q20.12), fixed-point constants and the
// scheduler state encoding. No ports.
package sim_pkg;

    localparam int unsigned FRAC_BITS = 12;
    localparam int unsigned COORD_W   = 32;

    localparam logic signed [COORD_W-1:0] FIX_ONE = 32'sh0000_1000;
    localparam logic signed [COORD_W-1:0] FIX_TWO = 32'sh0000_2000;

    typedef enum logic [2:0] {
        StIdle,
        StVerlet,
        StIssue,
        StWait,
        StWriteA,
        StWriteB,
        StDone
    } sched_state_e;

endpackage

// File: rtl/sim_step_scheduler_if.sv
// Bundle between the step scheduler and its surroundings (frame timer,
// node array, shared constraint solver).
//   step_start                 frame timer step request
//   pos_x_flat / pos_y_flat    node positions, node k at [k*W +: W]
//   verlet_state               broadcast integrate strobe
//   fix_en / fix_x / fix_y     one-hot write-back strobe and coordinate
//   req_*                      solver request (valid/ready + endpoints)
//   resp_*                     solver result strobe + corrected endpoints
//   busy / step_done / step_overrun  status
// master: scheduler side. slave: environment side.
interface sim_step_scheduler_if #(
    parameter int unsigned NUM_NODES = 4,
    parameter int unsigned W         = 32
);
    logic                   step_start;
    logic [NUM_NODES*W-1:0] pos_x_flat;
    logic [NUM_NODES*W-1:0] pos_y_flat;
    logic                   verlet_state;
    logic [NUM_NODES-1:0]   fix_en;
    logic [W-1:0]           fix_x;
    logic [W-1:0]           fix_y;
    logic                   req_valid;
    logic                   req_ready;
    logic [W-1:0]           req_ax;
    logic [W-1:0]           req_ay;
    logic [W-1:0]           req_bx;
    logic [W-1:0]           req_by;
    logic                   resp_valid;
    logic [W-1:0]           resp_ax;
    logic [W-1:0]           resp_ay;
    logic [W-1:0]           resp_bx;
    logic [W-1:0]           resp_by;
    logic                   busy;
    logic                   step_done;
    logic                   step_overrun;

    modport master (
        input  step_start, pos_x_flat, pos_y_flat, req_ready,
        input  resp_valid, resp_ax, resp_ay, resp_bx, resp_by,
        output verlet_state, fix_en, fix_x, fix_y,
        output req_valid, req_ax, req_ay, req_bx, req_by,
        output busy, step_done, step_overrun
    );

    modport slave (
        output step_start, pos_x_flat, pos_y_flat, req_ready,
        output resp_valid, resp_ax, resp_ay, resp_bx, resp_by,
        input  verlet_state, fix_en, fix_x, fix_y,
        input  req_valid, req_ax, req_ay, req_bx, req_by,
        input  busy, step_done, step_overrun
    );

endinterface

// File: rtl/link_operand_mux.sv
// Selects the endpoints of link (link, link+1) from the flat position buses
// and presents them as solver operands. Operands are forced to zero when
// en is low so the request bus is quiet outside of an issue.
//   en                   operand enable (scheduler in issue state)
//   link                 link index, 0 .. NUM_NODES-2
//   pos_x_flat/pos_y_flat  node positions
//   ax, ay, bx, by       endpoints a = node link, b = node link+1
module link_operand_mux #(
    parameter int unsigned NUM_NODES = 4,
    parameter int unsigned W         = 32,
    parameter int unsigned LINK_W    = 2
) (
    input  logic                   en,
    input  logic [LINK_W-1:0]      link,
    input  logic [NUM_NODES*W-1:0] pos_x_flat,
    input  logic [NUM_NODES*W-1:0] pos_y_flat,
    output logic [W-1:0]           ax,
    output logic [W-1:0]           ay,
    output logic [W-1:0]           bx,
    output logic [W-1:0]           by
);

    logic [W-1:0]      xs [NUM_NODES];
    logic [W-1:0]      ys [NUM_NODES];
    logic [LINK_W-1:0] idx_b;

    for (genvar k = 0; k < NUM_NODES; k++) begin : g_unpack
        assign xs[k] = pos_x_flat[k*W +: W];
        assign ys[k] = pos_y_flat[k*W +: W];
    end

    // LINK_W holds NUM_NODES-1, so link+1 never wraps for a legal link.
    assign idx_b = link + LINK_W'(1);

    always_comb begin
        ax = '0;
        ay = '0;
        bx = '0;
        by = '0;
        if (en) begin
            ax = xs[link];
            ay = ys[link];
            bx = xs[idx_b];
            by = ys[idx_b];
        end
    end

endmodule

// File: rtl/sim_step_scheduler.sv
// Sequences one simulation step: one Verlet integrate strobe to all nodes,
// then ITERS relaxation passes over every link (i, i+1) through a single
// time-shared constraint solver, writing corrected positions back one node
// per cycle.
//   clk, reset   clock; synchronous active-high reset (also aborts a step)
//   bus          sim_step_scheduler_if.master, see interface header
// Optional build macro PIN_NODE0_EN: node 0 is an anchor, so the link-0
// write-back of endpoint a is suppressed (the cycle is still spent).
module sim_step_scheduler
    import sim_pkg::*;
#(
    parameter int unsigned NUM_NODES = 4,
    parameter int unsigned ITERS     = 2,
    parameter int unsigned W         = COORD_W
) (
    input  logic                 clk,
    input  logic                 reset,
    sim_step_scheduler_if.master bus
);

    // Link index also has to hold link+1 for the one-hot shift.
    localparam int unsigned LINK_W = $clog2(NUM_NODES);
    localparam int unsigned ITER_W = (ITERS > 1) ? $clog2(ITERS) : 1;

    sched_state_e      state_q, state_d;
    logic [LINK_W-1:0] link_q, link_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [W-1:0]      cap_ax_q, cap_ay_q, cap_bx_q, cap_by_q;
    logic              cap_load;
    logic              overrun_q, overrun_d;

    logic                 verlet_state;
    logic [NUM_NODES-1:0] fix_en;
    logic [W-1:0]         fix_x, fix_y;
    logic                 req_valid;
    logic                 step_done;
    logic [NUM_NODES-1:0] one_a;
    logic [W-1:0]         op_ax, op_ay, op_bx, op_by;

    assign one_a = NUM_NODES'(1) << link_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            link_q    <= '0;
            iter_q    <= '0;
            cap_ax_q  <= '0;
            cap_ay_q  <= '0;
            cap_bx_q  <= '0;
            cap_by_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            link_q    <= link_d;
            iter_q    <= iter_d;
            overrun_q <= overrun_d;
            if (cap_load) begin
                cap_ax_q <= bus.resp_ax;
                cap_ay_q <= bus.resp_ay;
                cap_bx_q <= bus.resp_bx;
                cap_by_q <= bus.resp_by;
            end
        end
    end

    // A request is dropped whenever a step is already running.
    assign overrun_d = bus.step_start && (state_q != StIdle);

    always_comb begin
        state_d      = state_q;
        link_d       = link_q;
        iter_d       = iter_q;
        cap_load     = 1'b0;
        verlet_state = 1'b0;
        fix_en       = '0;
        fix_x        = '0;
        fix_y        = '0;
        req_valid    = 1'b0;
        step_done    = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.step_start) begin
                    link_d  = '0;
                    iter_d  = '0;
                    state_d = StVerlet;
                end
            end
            StVerlet: begin
                verlet_state = 1'b1;
                state_d      = StIssue;
            end
            StIssue: begin
                req_valid = 1'b1;
                if (bus.req_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (bus.resp_valid) begin
                    cap_load = 1'b1;
                    state_d  = StWriteA;
                end
            end
            StWriteA: begin
`ifdef PIN_NODE0_EN
                fix_en = (link_q == '0) ? '0 : one_a;
`else
                fix_en = one_a;
`endif
                fix_x   = cap_ax_q;
                fix_y   = cap_ay_q;
                state_d = StWriteB;
            end
            StWriteB: begin
                fix_en = one_a << 1;
                fix_x  = cap_bx_q;
                fix_y  = cap_by_q;
                if (link_q == LINK_W'(NUM_NODES - 2)) begin
                    link_d = '0;
                    if (iter_q == ITER_W'(ITERS - 1)) begin
                        state_d = StDone;
                    end else begin
                        iter_d  = iter_q + ITER_W'(1);
                        state_d = StIssue;
                    end
                end else begin
                    link_d  = link_q + LINK_W'(1);
                    state_d = StIssue;
                end
            end
            StDone: begin
                step_done = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    link_operand_mux #(
        .NUM_NODES (NUM_NODES),
        .W         (W),
        .LINK_W    (LINK_W)
    ) u_link_operand_mux (
        .en         (req_valid),
        .link       (link_q),
        .pos_x_flat (bus.pos_x_flat),
        .pos_y_flat (bus.pos_y_flat),
        .ax         (op_ax),
        .ay         (op_ay),
        .bx         (op_bx),
        .by         (op_by)
    );

    assign bus.verlet_state = verlet_state;
    assign bus.fix_en       = fix_en;
    assign bus.fix_x        = fix_x;
    assign bus.fix_y        = fix_y;
    assign bus.req_valid    = req_valid;
    assign bus.req_ax       = op_ax;
    assign bus.req_ay       = op_ay;
    assign bus.req_bx       = op_bx;
    assign bus.req_by       = op_by;
    assign bus.busy         = (state_q != StIdle);
    assign bus.step_done    = step_done;
    assign bus.step_overrun = overrun_q;

endmodule

// File: tb/tb_sim_step_scheduler.sv
// Directed bench for sim_step_scheduler: NUM_NODES=4, ITERS=2.
module tb_sim_step_scheduler;
    import sim_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned IT = 2;
    localparam int unsigned W  = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sim_step_scheduler_if #(.NUM_NODES(N), .W(W)) bus ();

    sim_step_scheduler #(
        .NUM_NODES (N),
        .ITERS     (IT),
        .W         (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [W-1:0] px [N];
    logic [W-1:0] py [N];

    // Hand-derived one-hot write-back strobes per link.
    logic [N-1:0] en_a_tab [3] = '{4'b0001, 4'b0010, 4'b0100};
    logic [N-1:0] en_b_tab [3] = '{4'b0010, 4'b0100, 4'b1000};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_verlet"}, bus.verlet_state, 0);
        chk({tag, "_fix_en"}, bus.fix_en, 0);
        chk({tag, "_fix_x"}, bus.fix_x, 0);
        chk({tag, "_fix_y"}, bus.fix_y, 0);
        chk({tag, "_req_valid"}, bus.req_valid, 0);
        chk({tag, "_req_ax"}, bus.req_ax, 0);
        chk({tag, "_req_by"}, bus.req_by, 0);
        chk({tag, "_done"}, bus.step_done, 0);
        chk({tag, "_overrun"}, bus.step_overrun, 0);
    endtask

    // Entered right after the edge that moved the DUT into ISSUE for link k.
    task automatic do_link(input int k, input int it, input int stall,
                           input bit raise_ovr, input bit expect_ovr);
        logic [W-1:0] rax, ray, rbx, rby;
        logic [N-1:0] ea;
        rax = 32'h000A_0000 | W'(k) | (W'(it) << 4);
        ray = 32'h000B_0000 | W'(k) | (W'(it) << 4);
        rbx = 32'h000C_0000 | W'(k) | (W'(it) << 4);
        rby = 32'h000D_0000 | W'(k) | (W'(it) << 4);
        if (k == 1) begin
            rax = 32'h000C_8000;
            ray = 32'h0000_A000;
            rbx = 32'h000D_2000;
            rby = 32'h0001_4000;
        end
        ea = en_a_tab[k];
`ifdef PIN_NODE0_EN
        if (k == 0) ea = '0;
`endif
        bus.req_ready = (stall == 0);
        chk("issue_valid", bus.req_valid, 1);
        chk("issue_ax", bus.req_ax, px[k]);
        chk("issue_ay", bus.req_ay, py[k]);
        chk("issue_bx", bus.req_bx, px[k+1]);
        chk("issue_by", bus.req_by, py[k+1]);
        chk("issue_fix_en", bus.fix_en, 0);
        chk("issue_overrun", bus.step_overrun, expect_ovr);
        for (int s = 0; s < stall; s++) begin
            tick();
            chk("stall_valid", bus.req_valid, 1);
            chk("stall_ax", bus.req_ax, px[k]);
            chk("stall_ay", bus.req_ay, py[k]);
            chk("stall_bx", bus.req_bx, px[k+1]);
            chk("stall_by", bus.req_by, py[k+1]);
            if (s == stall - 1) bus.req_ready = 1'b1;
        end
        tick();
        bus.req_ready = 1'b0;
        chk("wait_valid", bus.req_valid, 0);
        chk("wait_busy", bus.busy, 1);
        chk("wait_fix_en", bus.fix_en, 0);
        chk("wait_overrun", bus.step_overrun, 0);
        bus.resp_valid = 1'b1;
        bus.resp_ax = rax;
        bus.resp_ay = ray;
        bus.resp_bx = rbx;
        bus.resp_by = rby;
        tick();
        bus.resp_valid = 1'b0;
        bus.resp_ax = 32'hDEAD_BEEF;
        bus.resp_ay = 32'hDEAD_BEEF;
        bus.resp_bx = 32'hDEAD_BEEF;
        bus.resp_by = 32'hDEAD_BEEF;
        chk("wa_fix_en", bus.fix_en, ea);
        chk("wa_fix_x", bus.fix_x, rax);
        chk("wa_fix_y", bus.fix_y, ray);
        chk("wa_verlet", bus.verlet_state, 0);
        chk("wa_done", bus.step_done, 0);
        tick();
        chk("wb_fix_en", bus.fix_en, en_b_tab[k]);
        chk("wb_fix_x", bus.fix_x, rbx);
        chk("wb_fix_y", bus.fix_y, rby);
        chk("wb_done", bus.step_done, 0);
        if (raise_ovr) bus.step_start = 1'b1;
        tick();
        bus.step_start = 1'b0;
    endtask

    // step_start is sampled on the first tick (edge 0).
    task automatic run_step(input int stall_link, input int stall, input bit ovr);
        bus.step_start = 1'b1;
        tick();
        bus.step_start = 1'b0;
        chk("verlet_hi", bus.verlet_state, 1);
        chk("verlet_busy", bus.busy, 1);
        chk("verlet_fix_en", bus.fix_en, 0);
        chk("verlet_req", bus.req_valid, 0);
        tick();
        chk("verlet_lo", bus.verlet_state, 0);
        for (int it = 0; it < int'(IT); it++) begin
            for (int k = 0; k < int'(N) - 1; k++) begin
                do_link(k, it, (k == stall_link && it == 0) ? stall : 0,
                        ovr && it == 0 && k == 0, ovr && it == 0 && k == 1);
            end
        end
        chk("done_hi", bus.step_done, 1);
        chk("done_busy", bus.busy, 1);
        chk("done_fix_en", bus.fix_en, 0);
        tick();
        chk("after_done_lo", bus.step_done, 0);
        chk("after_done_busy", bus.busy, 0);
        tick();
        chk("idle_done_lo", bus.step_done, 0);
        chk("idle_busy", bus.busy, 0);
        chk("idle_verlet", bus.verlet_state, 0);
    endtask

    initial begin
        reset = 1'b1;
        bus.step_start = 1'b0;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_ax = '0;
        bus.resp_ay = '0;
        bus.resp_bx = '0;
        bus.resp_by = '0;
        for (int k = 0; k < int'(N); k++) begin
            px[k] = FIX_ONE + W'(k) * FIX_TWO;
            py[k] = W'(k + 8) << FRAC_BITS;
            bus.pos_x_flat[k*W +: W] = px[k];
            bus.pos_y_flat[k*W +: W] = py[k];
        end
        tick();
        tick();
        reset = 1'b0;
        chk_quiet("reset");

        // Zero-wait solver: done on edge 25.
        run_step(-1, 0, 1'b0);

        // Link 1 stalled 3 cycles in ISSUE: done on edge 28.
        run_step(1, 3, 1'b0);

        // step_start sampled on edge 5 while busy.
        run_step(-1, 0, 1'b1);

        // Reset while the solver transaction is outstanding.
        bus.step_start = 1'b1;
        tick();
        bus.step_start = 1'b0;
        tick();
        bus.req_ready = 1'b1;
        chk("rst_issue", bus.req_valid, 1);
        tick();
        bus.req_ready = 1'b0;
        chk("rst_wait_busy", bus.busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_quiet("rst_mid");
        bus.resp_valid = 1'b1;
        bus.resp_ax = 32'h1234_5678;
        bus.resp_ay = 32'h1234_5678;
        bus.resp_bx = 32'h1234_5678;
        bus.resp_by = 32'h1234_5678;
        tick();
        bus.resp_valid = 1'b0;
        chk_quiet("stale_resp");
        tick();
        chk_quiet("stale_resp2");

        run_step(-1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
